// File: rtl/prng_pkg.sv
// Shared types and default constants for the PRNG sequencers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prng_pkg;

  // Sequencer FSM: CLR waits for the multiplier's done to fall, MUL waits for
  // a product, OUT presents the new state until the consumer takes it.
  typedef enum logic [1:0] {
    CLR = 2'd0,
    MUL = 2'd1,
    OUT = 2'd2
  } lcg_state_t;

  // Default LCG constants: x(n+1) = (5*x(n) + 3) mod 2^W, starting from 7.
  localparam int LCG_A_DEF    = 5;
  localparam int LCG_C_DEF    = 3;
  localparam int LCG_SEED_DEF = 7;

endpackage

// File: rtl/lcg_seq.sv
// Linear-congruential sequencer driving an external shared multiplier: x <= (A*x + C) mod 2^W.
// Latency: 1 cycle CLR->MUL, multiplier latency, CLR until done falls, 1 cycle into OUT.
// Backpressure: out_data/out_valid held in OUT until out_ready; no multiply is started meanwhile.
module lcg_seq
  import prng_pkg::*;
#(
  parameter int                  in_width  = 4,
  parameter int                  out_width = in_width * 2,
  parameter logic [in_width-1:0] LCG_A     = in_width'(LCG_A_DEF),
  parameter logic [in_width-1:0] LCG_C     = in_width'(LCG_C_DEF),
  parameter logic [in_width-1:0] LCG_SEED  = in_width'(LCG_SEED_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_load,
  input  logic [in_width-1:0]  seed_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [in_width-1:0]  out_data,
  output logic [in_width-1:0]  mult_multiplicand,
  output logic [in_width-1:0]  mult_multiplier,
  output logic                 mult_enable,
  input  logic                 mult_done,
  input  logic [out_width-1:0] mult_result
);

  lcg_state_t          state;
  logic                pub;     // set once a new x is computed: CLR then heads to OUT, not MUL
  logic [in_width-1:0] x;

  // The product A*x always fits in out_width; only its low W bits feed the
  // modular update, the upper bits are intentionally ignored.
  logic unused_result_hi;
  assign unused_result_hi = ^mult_result[out_width-1:in_width];

  // Sequencer FSM and state register; reset, then seed load, take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR;
      pub   <= 1'b0;
      x     <= LCG_SEED;
    end else if (seed_load) begin
      // Any product in flight is dropped; the seed itself is never published.
      state <= CLR;
      pub   <= 1'b0;
      x     <= seed_value;
    end else begin
      unique case (state)
        CLR: begin
          // A done still high from the previous multiply must not be taken as
          // a fresh result, so only move on once it has fallen.
          if (!mult_done) begin
            state <= pub ? OUT : MUL;
          end
        end
        MUL: begin
          if (mult_done) begin
            x     <= mult_result[in_width-1:0] + LCG_C;
            pub   <= 1'b1;
            state <= CLR;
          end
        end
        OUT: begin
          if (out_ready) begin
            pub   <= 1'b0;
            state <= CLR;
          end
        end
        default: begin
          state <= CLR;
          pub   <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the FSM state and x: nothing depends
  // combinationally on out_ready or mult_done.
  always_comb begin
    out_valid         = (state == OUT);
    out_data          = x;
    mult_enable       = (state == MUL);
    mult_multiplicand = x;
    mult_multiplier   = LCG_A;
  end

  // A presented value is held until it is taken, unless reseeded or reset.
  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !seed_load) |=> (out_valid && $stable(out_data)));

  // The operand stays stable for the multiplier while it is working.
  a_operand_stable : assert property (@(posedge clk) disable iff (rst)
    (mult_enable && !mult_done && !seed_load) |=> $stable(mult_multiplicand));

endmodule

// File: tb/tb_lcg_seq.sv
// Directed bench for lcg_seq with a behavioural multiplier of adjustable latency and done hold.
// Latency: n/a (testbench).
// Backpressure: driven by the bench through out_ready.
module tb_lcg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seed_load = 1'b0;
  logic [3:0] seed_value = 4'd0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] out_data;
  logic [3:0] mult_multiplicand;
  logic [3:0] mult_multiplier;
  logic       mult_enable;
  logic       mult_done;
  logic [7:0] mult_result;

  int lat  = 3;   // cycles from enable seen to done
  int hold = 0;   // extra cycles done stays high after enable drops
  int cnt  = 0;
  int hcnt = 0;
  int rises = 0;
  logic en_prev = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcg_seq #(
    .in_width (4),
    .out_width(8),
    .LCG_A    (4'd5),
    .LCG_C    (4'd3),
    .LCG_SEED (4'd7)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .seed_load        (seed_load),
    .seed_value       (seed_value),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .mult_multiplicand(mult_multiplicand),
    .mult_multiplier  (mult_multiplier),
    .mult_enable      (mult_enable),
    .mult_done        (mult_done),
    .mult_result      (mult_result)
  );

  // behavioural multiplier: done after lat enabled cycles, kept hold cycles after enable drops
  always @(posedge clk) begin
    if (rst) begin
      cnt       <= 0;
      hcnt      <= 0;
      mult_done <= 1'b0;
      mult_result <= 8'd0;
    end else if (mult_enable) begin
      hcnt <= 0;
      if (!mult_done) begin
        if (cnt + 1 >= lat) begin
          mult_done   <= 1'b1;
          mult_result <= 8'(mult_multiplicand) * 8'(mult_multiplier);
          cnt         <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end else begin
      cnt <= 0;
      if (mult_done) begin
        if (hcnt >= hold) begin
          mult_done <= 1'b0;
          hcnt      <= 0;
        end else begin
          hcnt <= hcnt + 1;
        end
      end
    end
  end

  // count multiply starts, to show each output costs exactly one multiply
  always @(negedge clk) begin
    if (rst) begin
      rises   <= 0;
      en_prev <= 1'b0;
    end else begin
      if (mult_enable && !en_prev) rises <= rises + 1;
      en_prev <= mult_enable;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input int h);
    rst = 1'b1;
    seed_load = 1'b0;
    lat  = l;
    hold = h;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // wait for a pending transfer, record it, then let the edge complete it
  task automatic get_xfer(output logic [3:0] v);
    int n = 0;
    while (!(out_valid && out_ready) && n < 300) begin
      step();
      n++;
    end
    chk("xfer_wait", 32'(n < 300), 32'd1);
    v = out_data;
    step();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
    chk("valid_wait", 32'(n < 300), 32'd1);
  endtask

  task automatic wait_en(input logic need_done);
    int n = 0;
    while (!(mult_enable && (mult_done || !need_done)) && n < 300) begin
      step();
      n++;
    end
    chk("enable_wait", 32'(n < 300), 32'd1);
  endtask

  initial begin
    logic [3:0]  v;
    logic [15:0] seen;
    int          bad;
    logic [3:0]  seq [17];
    seq = '{4'd6, 4'd1, 4'd8, 4'd11, 4'd10, 4'd5, 4'd12, 4'd15,
            4'd14, 4'd9, 4'd0, 4'd3, 4'd2, 4'd13, 4'd4, 4'd7, 4'd6};

    // reset state
    do_reset(3, 0);
    rst = 1'b1;
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd7);
    chk("rst_enable", 32'(mult_enable), 32'd0);
    chk("rst_multiplier", 32'(mult_multiplier), 32'd5);
    chk("rst_multiplicand", 32'(mult_multiplicand), 32'd7);
    rst = 1'b0;

    // full period from the reset seed
    seen = '0;
    for (int i = 0; i < 17; i++) begin
      get_xfer(v);
      chk($sformatf("period_%0d", i), 32'(v), 32'(seq[i]));
      if (i < 16) seen[v] = 1'b1;
      if (i == 16) chk("period_starts", 32'(rises), 32'd17);
    end
    chk("period_distinct", 32'(seen), 32'h0000ffff);

    // back-pressure: first value held, no multiply started meanwhile
    do_reset(3, 0);
    out_ready = 1'b0;
    wait_valid();
    bad = 0;
    repeat (20) begin
      step();
      if (!out_valid || out_data != 4'd6 || mult_enable) bad++;
    end
    chk("bp_stall_cycles_bad", 32'(bad), 32'd0);
    out_ready = 1'b1;
    get_xfer(v);
    chk("bp_first", 32'(v), 32'd6);
    get_xfer(v);
    chk("bp_second", 32'(v), 32'd1);

    // seed load while multiplying: product discarded
    wait_en(1'b0);
    seed_load  = 1'b1;
    seed_value = 4'd0;
    step();
    seed_load = 1'b0;
    chk("seed_enable_drop", 32'(mult_enable), 32'd0);
    chk("seed_valid_low", 32'(out_valid), 32'd0);
    chk("seed_state", 32'(out_data), 32'd0);
    get_xfer(v);
    chk("seed_first", 32'(v), 32'd3);
    get_xfer(v);
    chk("seed_second", 32'(v), 32'd2);

    // seed load in the same cycle as done: load wins
    do_reset(1, 0);
    wait_en(1'b1);
    seed_load  = 1'b1;
    seed_value = 4'd9;
    step();
    seed_load = 1'b0;
    chk("seed_vs_done_state", 32'(out_data), 32'd9);
    get_xfer(v);
    chk("seed_vs_done_first", 32'(v), 32'd0);
    get_xfer(v);
    chk("seed_vs_done_second", 32'(v), 32'd3);

    // seed load in the same cycle as a transfer: consumer gets old x
    wait_valid();
    v = out_data;
    seed_load  = 1'b1;
    seed_value = 4'd4;
    step();
    seed_load = 1'b0;
    chk("seed_xfer_old", 32'(v), 32'd2);
    get_xfer(v);
    chk("seed_xfer_next", 32'(v), 32'd7);

    // slow done with a long hold, then fast done with a long hold
    for (int r = 0; r < 2; r++) begin
      do_reset((r == 0) ? 7 : 1, 3);
      for (int i = 0; i < 6; i++) begin
        get_xfer(v);
        chk($sformatf("slow%0d_%0d", r, i), 32'(v), 32'(seq[i]));
      end
      chk($sformatf("slow%0d_starts", r), 32'(rises), 32'd6);
    end

    // reset mid-multiply: enable drops the next cycle
    do_reset(7, 0);
    wait_en(1'b0);
    rst = 1'b1;
    step();
    chk("rst_mul_enable", 32'(mult_enable), 32'd0);
    rst = 1'b0;

    // reset mid-OUT: valid drops, state returns to seed, sequence restarts
    out_ready = 1'b0;
    wait_valid();
    chk("pre_rst_out", 32'(out_data), 32'd6);
    rst = 1'b1;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd7);
    rst = 1'b0;
    out_ready = 1'b1;
    get_xfer(v);
    chk("rst_out_restart", 32'(v), 32'd6);
    get_xfer(v);
    chk("rst_out_restart2", 32'(v), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
